// File: rtl/aux_input_conditioner.sv
// Board-input conditioner: synchronizes raw switches/buttons, debounces them on a
// shared sample tick, and emits stable levels plus single-cycle edge pulses.
module aux_input_conditioner #(
    parameter int unsigned SwtWidth      = 16,
    parameter int unsigned BtnWidth      = 5,
    parameter int unsigned TickCnt       = 1000000,
    parameter int unsigned StableSamples = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SwtWidth-1:0] swt_raw,
    input  logic [BtnWidth-1:0] btn_raw,
    output logic [SwtWidth-1:0] swt_db,
    output logic [BtnWidth-1:0] btn_db,
    output logic [BtnWidth-1:0] btn_press,
    output logic [BtnWidth-1:0] btn_release,
    output logic                swt_changed,
    output logic                tick
);

    localparam int unsigned NumBits   = SwtWidth + BtnWidth;
    localparam int unsigned HistDepth = StableSamples - 1;
    localparam int unsigned CntW      = (TickCnt > 1) ? $clog2(TickCnt) : 1;

    logic [CntW-1:0]    cnt;
    logic [CntW-1:0]    cnt_next;
    logic [NumBits-1:0] meta;
    logic [NumBits-1:0] sync;
    logic [NumBits-1:0] db;
    logic [NumBits-1:0] hist [HistDepth];
    logic [NumBits-1:0] agree_one;
    logic [NumBits-1:0] agree_zero;
    logic [NumBits-1:0] rise;
    logic [NumBits-1:0] fall;

    // Free-running sample-tick counter, 0..TickCnt-1.
    always_comb begin
        cnt_next = (cnt == CntW'(TickCnt - 1)) ? '0 : cnt + CntW'(1);
    end

    // A bit flips only when the current sample and the whole history agree.
    always_comb begin
        agree_one  = sync;
        agree_zero = ~sync;
        for (int unsigned j = 0; j < HistDepth; j++) begin
            agree_one  &= hist[j];
            agree_zero &= ~hist[j];
        end
        rise = agree_one & ~db;
        fall = agree_zero & db;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            meta        <= '0;
            sync        <= '0;
            db          <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            swt_changed <= 1'b0;
            tick        <= 1'b0;
            for (int unsigned j = 0; j < HistDepth; j++) begin
                hist[j] <= '0;
            end
        end else begin
            meta        <= {btn_raw, swt_raw};
            sync        <= meta;
            cnt         <= cnt_next;
            tick        <= (cnt_next == CntW'(TickCnt - 1));
            btn_press   <= '0;
            btn_release <= '0;
            swt_changed <= 1'b0;
            if (tick) begin
                db      <= (db | rise) & ~fall;
                hist[0] <= sync;
                for (int unsigned j = 1; j < HistDepth; j++) begin
                    hist[j] <= hist[j-1];
                end
                btn_press   <= rise[NumBits-1:SwtWidth];
                btn_release <= fall[NumBits-1:SwtWidth];
                swt_changed <= |(rise[SwtWidth-1:0] | fall[SwtWidth-1:0]);
            end
        end
    end

    assign swt_db = db[SwtWidth-1:0];
    assign btn_db = db[NumBits-1:SwtWidth];

endmodule

// File: tb/tb_aux_input_conditioner.sv
// Directed bench for aux_input_conditioner with a per-cycle reference model
// and hand-computed checkpoints, using TickCnt=4 and StableSamples=3.
module tb_aux_input_conditioner;

    localparam int unsigned SW     = 16;
    localparam int unsigned BW     = 5;
    localparam int unsigned NB     = SW + BW;
    localparam int unsigned TICK   = 4;
    localparam int unsigned STABLE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] swt_raw = '0;
    logic [BW-1:0] btn_raw = '0;
    logic [SW-1:0] swt_db;
    logic [BW-1:0] btn_db;
    logic [BW-1:0] btn_press;
    logic [BW-1:0] btn_release;
    logic          swt_changed;
    logic          tick;

    int n_checks = 0;
    int n_fail   = 0;
    int tcyc     = 0;

    aux_input_conditioner #(
        .SwtWidth(SW), .BtnWidth(BW), .TickCnt(TICK), .StableSamples(STABLE)
    ) dut (
        .clk(clk), .rst(rst), .swt_raw(swt_raw), .btn_raw(btn_raw),
        .swt_db(swt_db), .btn_db(btn_db), .btn_press(btn_press),
        .btn_release(btn_release), .swt_changed(swt_changed), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: raw value of each cycle is queued; the sample seen on the
    // tick of cycle c is the raw value of cycle c-2; a level is accepted when the
    // last STABLE tick samples agree and differ from the current level.
    logic [NB-1:0] raw_q[$];
    logic [NB-1:0] smp_q[$];
    logic [NB-1:0] m_db;
    logic [BW-1:0] m_press, m_rel;
    logic          m_chg, m_tick;
    int            m_cyc;
    bit            armed = 1'b0;

    always @(posedge clk) begin
        logic [NB-1:0] s, w, acc;
        int k;
        if (rst) begin
            raw_q.delete();
            smp_q.delete();
            m_db = '0; m_press = '0; m_rel = '0; m_chg = 1'b0; m_tick = 1'b0;
            m_cyc = 0;
            armed = 1'b1;
        end else begin
            s = (m_cyc >= 2) ? raw_q[m_cyc-2] : '0;
            raw_q.push_back({btn_raw, swt_raw});
            m_press = '0; m_rel = '0; m_chg = 1'b0;
            if (m_cyc % TICK == TICK - 1) begin
                smp_q.push_back(s);
                k = smp_q.size() - 1;
                acc = s ^ m_db;
                for (int j = 1; j < STABLE; j++) begin
                    w = (k >= j) ? smp_q[k-j] : '0;
                    acc &= ~(s ^ w);
                end
                m_press = acc[NB-1:SW] & s[NB-1:SW];
                m_rel   = acc[NB-1:SW] & ~s[NB-1:SW];
                m_chg   = |acc[SW-1:0];
                m_db    = m_db ^ acc;
            end
            m_tick = ((m_cyc + 1) % TICK == TICK - 1);
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("swt_db",      32'(swt_db),      32'(m_db[SW-1:0]));
            check("btn_db",      32'(btn_db),      32'(m_db[NB-1:SW]));
            check("btn_press",   32'(btn_press),   32'(m_press));
            check("btn_release", 32'(btn_release), 32'(m_rel));
            check("swt_changed", 32'(swt_changed), 32'(m_chg));
            check("tick",        32'(tick),        32'(m_tick));
        end
    end

    // Leaves the bench at the negedge inside cycle 0 (first cycle with rst=0).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        tcyc = 0;
    endtask

    task automatic at(input int c);
        while (tcyc < c) begin
            @(negedge clk);
            tcyc++;
        end
    endtask

    initial begin
        // Idle inputs: only the tick runs.
        do_reset();
        check("s1_tick_c0", 32'(tick), 32'd0);
        at(3);  check("s1_tick_c3", 32'(tick), 32'd1);
        at(4);  check("s1_tick_c4", 32'(tick), 32'd0);
        at(7);  check("s1_tick_c7", 32'(tick), 32'd1);
        at(11); check("s1_tick_c11", 32'(tick), 32'd1);
        at(39); check("s1_btn_db_c39", 32'(btn_db), 32'd0);
                check("s1_swt_db_c39", 32'(swt_db), 32'd0);

        // Button held through reset, then a short dropout, then a switch change.
        btn_raw = 5'b00001;
        do_reset();
        at(11); check("s2_btn_db_c11", 32'(btn_db), 32'd0);
        at(12); check("s2_btn_db_c12", 32'(btn_db), 32'd1);
                check("s2_press_c12", 32'(btn_press), 32'd1);
        at(13); check("s2_press_c13", 32'(btn_press), 32'd0);
        at(14); btn_raw = 5'b00000;
        at(19); btn_raw = 5'b00001;
        at(20); swt_raw = 16'h00A5;
        at(30); check("s3_btn_db_c30", 32'(btn_db), 32'd1);
        at(31); check("s4_swt_db_c31", 32'(swt_db), 32'h0000);
        at(32); check("s4_swt_db_c32", 32'(swt_db), 32'h00A5);
                check("s4_chg_c32", 32'(swt_changed), 32'd1);
        at(33); check("s4_chg_c33", 32'(swt_changed), 32'd0);
        at(45);

        // Two buttons pressed and released together.
        btn_raw = 5'b00000;
        do_reset();
        btn_raw = 5'b10001;
        at(11); check("s5_press_c11", 32'(btn_press), 32'd0);
        at(12); check("s5_press_c12", 32'(btn_press), 32'b10001);
                check("s5_btn_db_c12", 32'(btn_db), 32'b10001);
        at(13); check("s5_press_c13", 32'(btn_press), 32'd0);
        at(16); btn_raw = 5'b00000;
        at(27); check("s5_rel_c27", 32'(btn_release), 32'd0);
        at(28); check("s5_rel_c28", 32'(btn_release), 32'b10001);
                check("s5_btn_db_c28", 32'(btn_db), 32'd0);
        at(29); check("s5_rel_c29", 32'(btn_release), 32'd0);

        // Reset in the middle of a switch acceptance.
        at(32); btn_raw = 5'b00100;
        at(44); check("s6_btn_db_c44", 32'(btn_db), 32'b00100);
                swt_raw = 16'h1234;
        at(52); check("s6_swt_db_c52", 32'(swt_db), 32'h00A5);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        tcyc = 0;
        check("s6_btn_db_r0", 32'(btn_db), 32'd0);
        check("s6_swt_db_r0", 32'(swt_db), 32'd0);
        check("s6_tick_r0", 32'(tick), 32'd0);
        at(3);  check("s6_tick_r3", 32'(tick), 32'd1);
        at(11); check("s6_swt_db_r11", 32'(swt_db), 32'h0000);
        at(12); check("s6_swt_db_r12", 32'(swt_db), 32'h1234);
                check("s6_chg_r12", 32'(swt_changed), 32'd1);
                check("s6_press_r12", 32'(btn_press), 32'b00100);
        at(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
